mc_controller: RTL
==================

# mc_controller

Parametrised multicycle MIPS control unit: a main-decoder FSM plus an ALU decoder. It drives the existing multicycle datapath's selects and enables. Compared with the original controller it adds:
- memory wait states through a `mem_ready` handshake;
- BNE, ANDI, ORI, SLTI and JAL;
- illegal-instruction detection, with a selectable halt or skip mode;
- a retired-instruction counter.

It sits between the datapath (`op`, `funct`, `zero`) and the memory port.

## Interface
Parameters:
- WAIT_EN, 1: 1 = honour `mem_ready`; 0 = `mem_ready` is ignored and treated as constant 1.
- TRAP_HALT, 1: 1 = an illegal instruction parks the FSM in TRAP; 0 = it pulses `illegal` for one cycle and returns to FETCH.
- CNTW, 32: width of `instret`.

Ports (clock and reset first):
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen  out  1  PC register enable; equals pcwrite | (branch & (zero XOR isbne)).
- memreq  out  1  memory access request.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register enable.
- regwrite  out  1  register file write enable.
- alusrca  out  1  0 = PC, 1 = A.
- iord  out  1  0 = PC, 1 = ALUOut.
- immzero  out  1  1 = zero-extend the immediate (ANDI/ORI).
- memtoreg  out  2  00 = ALUOut, 01 = Data, 10 = PC.
- regdst  out  2  00 = rt, 01 = rd, 10 = r31.
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  out  1  illegal instruction flag.
- state  out  4  current FSM state (debug).
- instret  out  CNTW  count of retired instructions.

## Operation
State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JAL 12, TRAP 13.

Per-state controls. Any select not listed is 0; any enable not listed is 0. No output is ever x.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=pcwrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, add. Next state by opcode:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → EXECUTE, but only for a supported funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - beq 000100 or bne 000101 → BRANCH
  - addi 001000, slti 001010, andi 001100, ori 001101 → IEXEC
  - j 000010 → JUMP
  - jal 000011 → JAL
  - any other opcode, or an unsupported funct → TRAP
- MEMADR: alusrca=1, alusrcb=10, add. lw → MEMRD; sw → MEMWR.
- MEMRD: memreq=1, iord=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: regwrite, regdst=00, memtoreg=01.
- MEMWR: memreq=1, memwrite=1, iord=1. Stays until mem_ready, then goes to FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol taken from funct. Next state ALUWB.
- ALUWB: regwrite, regdst=01, memtoreg=00.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1. BEQ takes the branch when zero=1; BNE takes it when zero=0.
- IEXEC: alusrca=1, alusrcb=10. addi → add; slti → slt; andi → and with immzero=1; ori → or with immzero=1. Next state IWB.
- IWB: regwrite, regdst=00, memtoreg=00.
- JUMP: pcwrite, pcsrc=10.
- JAL: pcwrite, pcsrc=10, regwrite, regdst=10, memtoreg=10. r31 receives the already-incremented PC.
- TRAP: illegal=1, all enables 0.
  - TRAP_HALT=1: remains in TRAP until reset.
  - TRAP_HALT=0: one cycle in TRAP, then FETCH. The instruction is skipped and not counted.
- MEMWB, ALUWB, IWB, BRANCH, JUMP and JAL each go to FETCH.

## Timing
Reset:
- reset=0 asynchronously forces state=FETCH, instret=0, illegal=0.
- While reset=0, pcen, memreq, memwrite, irwrite and regwrite are forced to 0.
- The first fetch request is issued in the first cycle after reset rises.

Latency with zero wait states: lw 5 cycles; sw, R-type and I-ALU 4; beq, bne, j and jal 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Memory handshake:
- mem_ready is sampled at the rising edge and only matters while memreq=1.
- memreq, iord and memwrite stay stable until the edge at which mem_ready=1.

instret:
- Increments by 1 on the final cycle of each completed instruction, i.e. on every transition into FETCH except from TRAP.
- Wraps modulo 2^CNTW.
- A reset mid-instruction abandons the instruction without counting it.

## Test plan
- add (op 000000, funct 100000), WAIT_EN=1, mem_ready=1 → states 0,1,6,7,0; alucontrol=010 in EXECUTE; regwrite with regdst=01 in ALUWB; instret 0→1.
- lw with mem_ready held 0 for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total; irwrite pulses exactly once; memreq stays high throughout each wait.
- bne with zero=0 → pcen=1 in BRANCH. bne with zero=1 → pcen=0. beq with zero=1 → pcen=1. Each takes 3 cycles.
- jal → JAL state asserts regwrite, regdst=10, memtoreg=10, pcsrc=10 and pcen, all in the same cycle.
- op 111111 with TRAP_HALT=1 → state 13, illegal stays 1 for 20+ cycles, instret unchanged; asserting reset=0 clears all of these immediately and asynchronously.
- CNTW=4: 16 back-to-back j instructions → instret wraps from 15 to 0. Then set WAIT_EN=0 with mem_ready tied 0 → FETCH still completes in 1 cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: main-decoder FSM with memory wait states,
// illegal-instruction trapping and a retired-instruction counter.
module mc_controller #(
  parameter bit WAIT_EN   = 1'b1,
  parameter bit TRAP_HALT = 1'b1,
  parameter int CNTW      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pcen,
  output logic            memreq,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regwrite,
  output logic            alusrca,
  output logic            iord,
  output logic            immzero,
  output logic [1:0]      memtoreg,
  output logic [1:0]      regdst,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [2:0]      alucontrol,
  output logic            illegal,
  output logic [3:0]      state,
  output logic [CNTW-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] instret_q, instret_d;

  logic       ready;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pcwrite_c, branch_c, memreq_c, memwrite_c, irwrite_c, regwrite_c;
  logic       alusrca_c, iord_c, immzero_c, illegal_c;
  logic [1:0] memtoreg_c, regdst_c, alusrcb_c, pcsrc_c;
  logic [2:0] alucontrol_c;

  assign ready = WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pcwrite_c    = 1'b0;
    branch_c     = 1'b0;
    memreq_c     = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    iord_c       = 1'b0;
    immzero_c    = 1'b0;
    illegal_c    = 1'b0;
    memtoreg_c   = 2'b00;
    regdst_c     = 2'b00;
    alusrcb_c    = 2'b00;
    pcsrc_c      = 2'b00;
    alucontrol_c = 3'b000;
    case (state_q)
      S_FETCH: begin
        memreq_c     = 1'b1;
        alusrcb_c    = 2'b01;
        alucontrol_c = ALU_ADD;
        irwrite_c    = ready;
        pcwrite_c    = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb_c    = 2'b11;
        alucontrol_c = ALU_ADD;
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = funct_ok ? S_EXECUTE : S_TRAP;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = 2'b10;
        alucontrol_c = ALU_ADD;
        state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memreq_c = 1'b1;
        iord_c   = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memreq_c   = 1'b1;
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca_c    = 1'b1;
        alucontrol_c = funct_alu;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 2'b01;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c    = 1'b1;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = 2'b01;
        branch_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_IEXEC: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        case (op)
          OP_SLTI: alucontrol_c = ALU_SLT;
          OP_ANDI: begin alucontrol_c = ALU_AND; immzero_c = 1'b1; end
          OP_ORI:  begin alucontrol_c = ALU_OR;  immzero_c = 1'b1; end
          default: alucontrol_c = ALU_ADD;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b10;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pcwrite_c  = 1'b1;
        pcsrc_c    = 2'b10;
        regwrite_c = 1'b1;
        regdst_c   = 2'b10;
        memtoreg_c = 2'b10;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
        if (!TRAP_HALT) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // An instruction retires when it hands control back to FETCH; skipped traps do not.
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
      instret_d = instret_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign pcen       = reset & (pcwrite_c | (branch_c & (zero ^ (op == OP_BNE))));
  assign memreq     = reset & memreq_c;
  assign memwrite   = reset & memwrite_c;
  assign irwrite    = reset & irwrite_c;
  assign regwrite   = reset & regwrite_c;
  assign alusrca    = alusrca_c;
  assign iord       = iord_c;
  assign immzero    = immzero_c;
  assign memtoreg   = memtoreg_c;
  assign regdst     = regdst_c;
  assign alusrcb    = alusrcb_c;
  assign pcsrc      = pcsrc_c;
  assign alucontrol = alucontrol_c;
  assign illegal    = illegal_c;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule
